// File: rtl/hc595_pkg.sv
// Shared defaults and types for the sampled 74HC595-style shift/storage register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hc595_pkg;

    localparam int HC_WIDTH       = 8;
    localparam int HC_SYNC_STAGES = 2;
    localparam int HC_FILT_LEN    = 3;

    // One bit per stage, Q[1] is the first stage, Q[WIDTH] feeds the cascade output.
    typedef logic [HC_WIDTH:1] sr_t;

endpackage

// File: rtl/hc595_sampled_if.sv
// Pin-level bundle between the pad side and the hc595_sampled core.
// Latency: none, wires only.
// Backpressure: none; inputs are free-running sampled levels.
interface hc595_sampled_if #(
    parameter int WIDTH = hc595_pkg::HC_WIDTH
);

    logic             SER;
    logic             SRCLK;
    logic             SRCLR_N;
    logic             RCLK;
    logic             OE_N;
    logic [WIDTH:1]   Q;
    logic             QH_S;
    logic             Q_EN;

    modport master (
        output SER, SRCLK, SRCLR_N, RCLK, OE_N,
        input  Q, QH_S, Q_EN
    );

    modport slave (
        input  SER, SRCLK, SRCLR_N, RCLK, OE_N,
        output Q, QH_S, Q_EN
    );

endinterface

// File: rtl/hc_sync_edge.sv
// Synchronise an async clock-like level, optionally debounce it, and flag its rising edge.
// Latency: rise asserts SYNC_STAGES cycles after the input is first sampled high (+FILT_LEN with filter).
// Backpressure: none; pulses shorter than the filter/sync window may be lost.
// Optional debounce enabled by HC595_GLITCH_FILTER_EN.
module hc_sync_edge #(
    parameter int SYNC_STAGES = 2
`ifdef HC595_GLITCH_FILTER_EN
    ,
    parameter int FILT_LEN = 3
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   level;
    logic                   hist;

    // Synchroniser chain; loads 1 so a level held high across reset is not an edge.
    always_ff @(posedge clk) begin
        if (rst) chain <= '1;
        else     chain <= {chain[SYNC_STAGES-2:0], din};
    end

`ifdef HC595_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);
    logic          filt;
    logic [CW-1:0] cnt;

    // Debounce: flip the filtered level only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (chain[SYNC_STAGES-1] != filt) begin
            if (cnt == CW'(FILT_LEN - 1)) begin
                filt <= chain[SYNC_STAGES-1];
                cnt  <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign level = filt;
`else
    assign level = chain[SYNC_STAGES-1];
`endif

    // Edge history; rise is a one-cycle strobe on a 0->1 transition of the level.
    always_ff @(posedge clk) begin
        if (rst) hist <= 1'b1;
        else     hist <= level;
    end

    assign rise = level & ~hist;

endmodule

// File: rtl/hc595_sampled.sv
// 74HC595-style serial-in/parallel-out shift register with storage latch, single clock domain.
// Latency: SRCLK->QH_S and RCLK->Q are SYNC_STAGES+1 cycles (+FILT_LEN with filter); OE_N->Q_EN is SYNC_STAGES.
// Backpressure: none; external levels must be held long enough to be sampled.
// Optional SRCLK/RCLK debounce enabled by HC595_GLITCH_FILTER_EN.
module hc595_sampled
    import hc595_pkg::*;
#(
    parameter int WIDTH       = HC_WIDTH,
    parameter int SYNC_STAGES = HC_SYNC_STAGES,
    parameter int FILT_LEN    = HC_FILT_LEN
) (
    input  logic            CLK,
    input  logic            RST,
    hc595_sampled_if.slave  bus
);

    // SER must line up with the filtered SRCLK edge, so it is delayed by the same depth.
`ifdef HC595_GLITCH_FILTER_EN
    localparam int SER_DEPTH = SYNC_STAGES + FILT_LEN;
`else
    localparam int SER_DEPTH = SYNC_STAGES;
`endif

    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_params
        $error("hc595_sampled: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
    end

    logic [SER_DEPTH-1:0]   ser_chain;
    logic [SYNC_STAGES-1:0] clr_chain;
    logic [SYNC_STAGES-1:0] oe_chain;
    logic                   ser_sync;
    logic                   clr_n_sync;
    logic                   sh_rise;
    logic                   st_rise;
    logic [WIDTH:1]         sr;
    logic [WIDTH:1]         storage;

    // Plain synchronisers for data/control levels; clear and enable reset to inactive.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ser_chain <= '0;
            clr_chain <= '1;
            oe_chain  <= '1;
        end else begin
            ser_chain <= {ser_chain[SER_DEPTH-2:0], bus.SER};
            clr_chain <= {clr_chain[SYNC_STAGES-2:0], bus.SRCLR_N};
            oe_chain  <= {oe_chain[SYNC_STAGES-2:0], bus.OE_N};
        end
    end

    assign ser_sync   = ser_chain[SER_DEPTH-1];
    assign clr_n_sync = clr_chain[SYNC_STAGES-1];

    hc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
`ifdef HC595_GLITCH_FILTER_EN
        ,
        .FILT_LEN    (FILT_LEN)
`endif
    ) u_sh_edge (
        .clk  (CLK),
        .rst  (RST),
        .din  (bus.SRCLK),
        .rise (sh_rise)
    );

    hc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
`ifdef HC595_GLITCH_FILTER_EN
        ,
        .FILT_LEN    (FILT_LEN)
`endif
    ) u_st_edge (
        .clk  (CLK),
        .rst  (RST),
        .din  (bus.RCLK),
        .rise (st_rise)
    );

    // Shift register: clear beats shift; stage 1 takes SER, the top stage falls off.
    always_ff @(posedge CLK) begin
        if (RST)              sr <= '0;
        else if (!clr_n_sync) sr <= '0;
        else if (sh_rise)     sr <= {sr[WIDTH-1:1], ser_sync};
    end

    // Storage latch captures the pre-update shift value, so tied clocks store one stage behind.
    always_ff @(posedge CLK) begin
        if (RST)          storage <= '0;
        else if (st_rise) storage <= sr;
    end

    assign bus.Q    = storage;
    assign bus.QH_S = sr[WIDTH];
    assign bus.Q_EN = ~oe_chain[SYNC_STAGES-1];

endmodule

// File: tb/tb_hc595_sampled.sv
// Directed bench for hc595_sampled: reset, shift/store, cascade, tied clocks, clear, optional filter.
// Latency: checks edge-to-output delay against the expected cycle counts.
// Backpressure: n/a.
module tb_hc595_sampled;
    import hc595_pkg::*;

    localparam int S = HC_SYNC_STAGES;
`ifdef HC595_GLITCH_FILTER_EN
    localparam int LAT = HC_SYNC_STAGES + HC_FILT_LEN + 1;
`else
    localparam int LAT = HC_SYNC_STAGES + 1;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    sr_t  sr_m;
    sr_t  last_q;
    sr_t  pat;
    sr_t  exp_q[$];

    hc595_sampled_if #(.WIDTH(HC_WIDTH)) bus ();

    hc595_sampled #(
        .WIDTH       (HC_WIDTH),
        .SYNC_STAGES (HC_SYNC_STAGES),
        .FILT_LEN    (HC_FILT_LEN)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the next expected storage value and compare against Q.
    task automatic chk_q(input string tag);
        sr_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(bus.Q), 32'(e));
            last_q = e;
        end
    endtask

    task automatic sh_pulse(input logic v);
        bus.SER   = v;
        bus.SRCLK = 1'b0;
        tick(4);
        bus.SRCLK = 1'b1;
        tick(8);
        sr_m = {sr_m[HC_WIDTH-1:1], v};
    endtask

    task automatic shift_byte(input sr_t b);
        for (int i = HC_WIDTH; i >= 1; i--) sh_pulse(b[i]);
    endtask

    // RCLK pulse that also checks Q flips exactly LAT cycles after the rise.
    task automatic rclk_pulse(input sr_t e, input string tag);
        bus.RCLK = 1'b0;
        tick(4);
        exp_q.push_back(e);
        bus.RCLK = 1'b1;
        tick(LAT - 1);
        chk({tag, "_hold"}, 32'(bus.Q), 32'(last_q));
        tick(1);
        chk_q(tag);
        tick(4);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        sr_m = '0;
        last_q = '0;
        rst = 1'b1;
        bus.SER = 1'b1;
        bus.SRCLK = 1'b1;
        bus.RCLK = 1'b1;
        bus.SRCLR_N = 1'b1;
        bus.OE_N = 1'b1;
        tick(3);
        chk("rst_q", 32'(bus.Q), 32'h0);
        chk("rst_qh", 32'(bus.QH_S), 32'h0);
        chk("rst_qen", 32'(bus.Q_EN), 32'h0);

        rst = 1'b0;
        tick(20);
        chk("idle_q", 32'(bus.Q), 32'h0);
        chk("idle_qh", 32'(bus.QH_S), 32'h0);
        chk("idle_qen", 32'(bus.Q_EN), 32'h0);

        bus.OE_N = 1'b0;
        tick(S - 1);
        chk("oe_lat_hold", 32'(bus.Q_EN), 32'h0);
        tick(1);
        chk("oe_lat", 32'(bus.Q_EN), 32'h1);

        pat = 8'hB2;
        shift_byte(pat);
        chk("b2_qh", 32'(bus.QH_S), 32'h1);
        rclk_pulse(8'hB2, "b2_store");
        chk("b2_qen", 32'(bus.Q_EN), 32'h1);

        for (int i = 0; i < HC_WIDTH; i++) begin
            sh_pulse(1'b0);
            chk($sformatf("cascade_%0d", i), 32'(bus.QH_S), 32'(sr_m[HC_WIDTH]));
        end
        chk("cascade_end", 32'(bus.QH_S), 32'h0);
        chk("b2_kept", 32'(bus.Q), 32'hB2);

        pat = 8'h01;
        shift_byte(pat);
        bus.SER = 1'b1;
        bus.SRCLK = 1'b0;
        bus.RCLK = 1'b0;
        tick(4);
        exp_q.push_back(8'h01);
        bus.SRCLK = 1'b1;
        bus.RCLK = 1'b1;
        tick(LAT + 4);
        sr_m = {sr_m[HC_WIDTH-1:1], 1'b1};
        chk_q("tied_pre_shift");
        rclk_pulse(8'h03, "tied_after");

        pat = 8'hFF;
        shift_byte(pat);
        rclk_pulse(8'hFF, "ff_store");
        chk("ff_qh", 32'(bus.QH_S), 32'h1);
        bus.SRCLK = 1'b0;
        tick(4);
        bus.SRCLK = 1'b1;
        bus.SRCLR_N = 1'b0;
        tick(LAT + 4);
        sr_m = '0;
        chk("clr_qh", 32'(bus.QH_S), 32'h0);
        chk("clr_q_kept", 32'(bus.Q), 32'hFF);
        bus.SRCLR_N = 1'b1;
        tick(6);
        rclk_pulse(8'h00, "clr_sr_zero");

`ifdef HC595_GLITCH_FILTER_EN
        pat = 8'h40;
        shift_byte(pat);
        chk("filt_setup_qh", 32'(bus.QH_S), 32'h0);
        bus.SER = 1'b0;
        bus.SRCLK = 1'b0;
        tick(1);
        bus.SRCLK = 1'b1;
        tick(12);
        chk("filt_glitch_qh", 32'(bus.QH_S), 32'h0);
        bus.SRCLK = 1'b0;
        tick(4);
        bus.SRCLK = 1'b1;
        tick(HC_FILT_LEN);
        bus.SRCLK = 1'b0;
        tick(LAT - 1 - HC_FILT_LEN);
        chk("filt_lat_hold", 32'(bus.QH_S), 32'h0);
        tick(1);
        chk("filt_lat", 32'(bus.QH_S), 32'h1);
        tick(10);
        rclk_pulse(8'h80, "filt_one_shift");
`endif

        rst = 1'b1;
        tick(2);
        chk("midrst_q", 32'(bus.Q), 32'h0);
        chk("midrst_qh", 32'(bus.QH_S), 32'h0);
        chk("midrst_qen", 32'(bus.Q_EN), 32'h0);
        rst = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
